// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit:
// fetch FSM states, next-PC select codes, reset PC and NOP word.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_DONE = 2'b10
   } fetch_state_t;

   typedef enum logic [1:0] {
      PC_SEQ = 2'b00,
      PC_BR  = 2'b01,
      PC_JMP = 2'b10,
      PC_JR  = 2'b11
   } pc_sel_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_1000;
   localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
   localparam int          ADDR_W_DEF   = 26;
   localparam int          TIMEOUT_DEF  = 16;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: sequential, branch,
// jump (region-relative) and register-indirect targets.
module pc_next_calc
   import instr_fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_sel,
   input  logic [15:0] br_imm,
   input  logic [25:0] jmp_addr,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc
);

   logic [31:0] pc_inc;

   assign pc_inc = pc + 32'd1;

   // pick the target; all arithmetic wraps modulo 2^32
   always_comb begin
      next_pc = pc_inc;
      unique case (pc_sel_t'(pc_sel))
         PC_SEQ: next_pc = pc_inc;
         PC_BR:  next_pc = pc_inc + sext16(br_imm);
         PC_JMP: next_pc = {pc[31:26], jmp_addr};
         PC_JR:  next_pc = jr_target;
         default: next_pc = pc_inc;
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, issues single
// outstanding word reads with a timeout, applies next-PC updates.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
   parameter int          ADDR_W      = ADDR_W_DEF,
   parameter int          TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FETCH_START,
   input  logic              PC_LOAD,
   input  logic [1:0]        PC_SEL,
   input  logic [15:0]       BR_IMM,
   input  logic [25:0]       JMP_ADDR,
   input  logic [31:0]       JR_TARGET,
   output logic              MEM_RD,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic [31:0]       MEM_RDATA,
   input  logic              MEM_READY,
   output logic [31:0]       INSTRUCTION,
   output logic [31:0]       PC,
   output logic              IR_VALID,
   output logic              BUSY,
   output logic              FETCH_ERR
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   fetch_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic             stale;
   logic [31:0]      next_pc;

   pc_next_calc u_pc_next (
      .pc        (PC),
      .pc_sel    (PC_SEL),
      .br_imm    (BR_IMM),
      .jmp_addr  (JMP_ADDR),
      .jr_target (JR_TARGET),
      .next_pc   (next_pc)
   );

   // PC register: updated only on a WB-stage load request
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         PC <= RESET_PC;
      end else if (PC_LOAD) begin
         PC <= next_pc;
      end
   end

   // fetch FSM with IR, timeout counter and registered handshake outputs;
   // stale marks a fetch whose PC was replaced while it was in flight
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= S_IDLE;
         cnt         <= '0;
         stale       <= 1'b0;
         MEM_RD      <= 1'b0;
         MEM_ADDR    <= '0;
         INSTRUCTION <= NOP_WORD;
         IR_VALID    <= 1'b0;
         BUSY        <= 1'b0;
         FETCH_ERR   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (FETCH_START) begin
                  state    <= S_REQ;
                  BUSY     <= 1'b1;
                  MEM_RD   <= 1'b1;
                  MEM_ADDR <= PC[ADDR_W-1:0];
                  cnt      <= '0;
                  stale    <= PC_LOAD;
               end
            end
            S_REQ: begin
               if (MEM_READY) begin
                  INSTRUCTION <= MEM_RDATA;
                  MEM_RD      <= 1'b0;
                  BUSY        <= 1'b0;
                  state       <= S_DONE;
               end else if (cnt == CNT_LAST) begin
                  INSTRUCTION <= NOP_WORD;
                  FETCH_ERR   <= 1'b1;
                  MEM_RD      <= 1'b0;
                  BUSY        <= 1'b0;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
               if (PC_LOAD) begin
                  stale <= 1'b1;
               end
            end
            S_DONE: begin
               IR_VALID <= !stale;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
         if (PC_LOAD || (state == S_IDLE && FETCH_START)) begin
            IR_VALID <= 1'b0;
         end
      end
   end

endmodule
